expr_eval: RTL and testbench

//  Downstream evaluation stage for the expression-checker character stream.

---
 rtl/expr_eval_pkg.sv | 19 +
 rtl/expr_eval_alu.sv | 22 ++
 rtl/expr_eval.sv | 96 +++++++++
 tb/tb_expr_eval.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/expr_eval_pkg.sv
// Shared types and character constants for the expression-evaluation stages.
package expr_eval_pkg;

  typedef enum logic [1:0] {
    StExpNum = 2'd0,
    StExpOp  = 2'd1,
    StErr    = 2'd3
  } state_e;

  localparam logic [7:0] Ch0    = 8'h30;
  localparam logic [7:0] Ch9    = 8'h39;
  localparam logic [7:0] ChPlus = 8'h2b;
  localparam logic [7:0] ChMul  = 8'h2a;

  function automatic logic is_digit(logic [7:0] c);
    return (c >= Ch0) && (c <= Ch9);
  endfunction

endpackage

// File: rtl/expr_eval_alu.sv
// Combinational arithmetic for the evaluator: term multiply by a digit and term accumulate.
module expr_eval_alu #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] sum,
  input  logic [W-1:0] prod,
  input  logic [3:0]   digit,
  output logic [W-1:0] prod_mul,
  output logic         mul_ovf,
  output logic [W-1:0] sum_add,
  output logic         add_carry
);

  logic [2*W-1:0] full_prod;

  assign full_prod = (2*W)'(prod) * (2*W)'(digit);
  assign prod_mul  = full_prod[W-1:0];
  assign mul_ovf   = |full_prod[2*W-1:W];

  assign {add_carry, sum_add} = {1'b0, sum} + {1'b0, prod};

endmodule

// File: rtl/expr_eval.sv
// Evaluates a digit/'+'/'*' character stream with '*' precedence; value valid when ok=1.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         restart,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         ok,
  output logic [W-1:0] result,
  output logic         ovf
);

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] prod_q, prod_d;
  logic         ovf_q, ovf_d;

  logic [W-1:0] prod_mul, sum_add;
  logic         mul_ovf, add_carry;

  // Low nibble of an ASCII digit is its value; only used when is_digit(in) holds.
  expr_eval_alu #(
    .W(W)
  ) u_alu (
    .sum      (sum_q),
    .prod     (prod_q),
    .digit    (in[3:0]),
    .prod_mul (prod_mul),
    .mul_ovf  (mul_ovf),
    .sum_add  (sum_add),
    .add_carry(add_carry)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StExpNum;
      sum_q   <= '0;
      prod_q  <= W'(1);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    if (restart) begin
      state_d = StExpNum;
      sum_d   = '0;
      prod_d  = W'(1);
      ovf_d   = 1'b0;
    end else if (in_valid) begin
      case (state_q)
        StExpNum: begin
          if (is_digit(in)) begin
            prod_d  = prod_mul;
            ovf_d   = ovf_q | mul_ovf;
            state_d = StExpOp;
          end else begin
            state_d = StErr;
          end
        end
        StExpOp: begin
          if (in == ChPlus) begin
            sum_d   = sum_add;
            prod_d  = W'(1);
            ovf_d   = ovf_q | add_carry;
            state_d = StExpNum;
          end else if (in == ChMul) begin
            state_d = StExpNum;
          end else begin
            state_d = StErr;
          end
        end
        StErr:   state_d = StErr;
        default: state_d = StErr;
      endcase
    end
  end

  // The result adder carry is deliberately not folded into ovf.
  assign ok     = (state_q == StExpOp);
  assign result = ok ? sum_add : '0;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed scoreboard bench for expr_eval (W=8).
module tb_expr_eval;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         restart;
  logic         in_valid;
  logic [7:0]   in;
  logic         ok;
  logic [W-1:0] result;
  logic         ovf;

  typedef struct {
    string        tag;
    logic         ok;
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  expr_eval #(
    .W(W)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (restart),
    .in_valid(in_valid),
    .in      (in),
    .ok      (ok),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".ok"}, 32'(ok), 32'(e.ok));
      check({e.tag, ".result"}, 32'(result), 32'(e.res));
      check({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  // Drive one cycle at negedge, push the expectation, compare just after the posedge.
  task automatic step(input string tag, input logic v, input logic [7:0] ch, input logic rs,
                      input logic e_ok, input logic [W-1:0] e_res, input logic e_ovf);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in       = ch;
    restart  = rs;
    e.tag = tag; e.ok = e_ok; e.res = e_res; e.ovf = e_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic put(input string tag, input logic [7:0] ch,
                     input logic e_ok, input logic [W-1:0] e_res, input logic e_ovf);
    step(tag, 1'b1, ch, 1'b0, e_ok, e_res, e_ovf);
  endtask

  initial begin
    exp_t e;
    clr_n    = 1'b0;
    restart  = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    e.tag = "reset"; e.ok = 1'b0; e.res = '0; e.ovf = 1'b0;
    sb.push_back(e);
    compare_head();
    @(negedge clk);
    clr_n = 1'b1;

    // Idle with a legal-looking character present but not qualified.
    for (int i = 0; i < 5; i++) step("idle", 1'b0, "7", 1'b0, 1'b0, 8'd0, 1'b0);

    // "3+4*5"
    put("s1_3", "3", 1'b1, 8'd3,  1'b0);
    put("s1_+", "+", 1'b0, 8'd0,  1'b0);
    put("s1_4", "4", 1'b1, 8'd7,  1'b0);
    put("s1_*", "*", 1'b0, 8'd0,  1'b0);
    put("s1_5", "5", 1'b1, 8'd23, 1'b0);
    step("hold", 1'b0, "+", 1'b0, 1'b1, 8'd23, 1'b0);
    step("hold", 1'b0, "x", 1'b0, 1'b1, 8'd23, 1'b0);

    // "9*9*9": 729 mod 256 = 217 with multiply overflow
    step("rs1", 1'b0, "0", 1'b1, 1'b0, 8'd0, 1'b0);
    put("s2_9a", "9", 1'b1, 8'd9,   1'b0);
    put("s2_*a", "*", 1'b0, 8'd0,   1'b0);
    put("s2_9b", "9", 1'b1, 8'd81,  1'b0);
    put("s2_*b", "*", 1'b0, 8'd0,   1'b0);
    put("s2_9c", "9", 1'b1, 8'd217, 1'b1);
    // continue "+8*" so ovf=1 when the async clear hits
    put("s2_+",  "+", 1'b0, 8'd0,   1'b1);
    put("s2_8",  "8", 1'b1, 8'd225, 1'b1);
    put("s2_*c", "*", 1'b0, 8'd0,   1'b1);

    // Async clear between edges, then "2" must not reuse the old product.
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    e.tag = "async_clr"; e.ok = 1'b0; e.res = '0; e.ovf = 1'b0;
    sb.push_back(e);
    compare_head();
    @(negedge clk);
    clr_n = 1'b1;
    put("s3_2", "2", 1'b1, 8'd2, 1'b0);

    // "9*9*3+9*9*3+0": result sum wraps without ovf; the '+' carry sets it.
    step("rs2", 1'b0, "0", 1'b1, 1'b0, 8'd0, 1'b0);
    put("s4_9a", "9", 1'b1, 8'd9,   1'b0);
    put("s4_*a", "*", 1'b0, 8'd0,   1'b0);
    put("s4_9b", "9", 1'b1, 8'd81,  1'b0);
    put("s4_*b", "*", 1'b0, 8'd0,   1'b0);
    put("s4_3a", "3", 1'b1, 8'd243, 1'b0);
    put("s4_+a", "+", 1'b0, 8'd0,   1'b0);
    put("s4_9c", "9", 1'b1, 8'd252, 1'b0);
    put("s4_*c", "*", 1'b0, 8'd0,   1'b0);
    put("s4_9d", "9", 1'b1, 8'd68,  1'b0);
    put("s4_*d", "*", 1'b0, 8'd0,   1'b0);
    put("s4_3b", "3", 1'b1, 8'd230, 1'b0);
    put("s4_+b", "+", 1'b0, 8'd0,   1'b1);
    put("s4_0",  "0", 1'b1, 8'd230, 1'b1);
    put("s4_*e", "*", 1'b0, 8'd0,   1'b1);
    put("s4_5",  "5", 1'b1, 8'd230, 1'b1);

    // "1++2": error is absorbing
    step("rs3", 1'b0, "0", 1'b1, 1'b0, 8'd0, 1'b0);
    put("s5_1",  "1", 1'b1, 8'd1, 1'b0);
    put("s5_+a", "+", 1'b0, 8'd0, 1'b0);
    put("s5_+b", "+", 1'b0, 8'd0, 1'b0);
    put("s5_2",  "2", 1'b0, 8'd0, 1'b0);
    step("rs4", 1'b0, "0", 1'b1, 1'b0, 8'd0, 1'b0);
    put("s5_6",  "6", 1'b1, 8'd6, 1'b0);

    // restart wins over a simultaneous character; a following digit proves '7' was dropped.
    step("rs_drop", 1'b1, "7", 1'b1, 1'b0, 8'd0, 1'b0);
    put("s6_2", "2", 1'b1, 8'd2, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
